utmi_rx_framer: RTL and testbench

- Sits between the UTMI+/ULPI PHY receive interface and the packet decoder.
- Turns the PHY's RxActive/RxValid/RxError byte stream into an AXI4-Stream of packet bytes. TLAST marks the final byte (the second CRC16 byte, or the lone PID of a handshake).
- Holds one byte so TLAST can be attached once RxActive falls.
- Detects PHY errors, babble (over-length packets) and downstream overflow, and truncates the packet cleanly.

---
 rtl/utmi_rx_framer_pkg.sv | 17 +
 rtl/utmi_rx_framer.sv | 163 ++++++++++++++++
 tb/tb_utmi_rx_framer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/utmi_rx_framer_pkg.sv
// Shared constants for the UTMI receive framer: error codes, length limit and
// one-hot receive state encodings.
package utmi_rx_framer_pkg;

  localparam int unsigned MAX_PACKET_LEN_DEF = 1027;

  localparam logic [1:0] RXERR_NONE     = 2'b00;
  localparam logic [1:0] RXERR_PHY      = 2'b01;
  localparam logic [1:0] RXERR_BABBLE   = 2'b10;
  localparam logic [1:0] RXERR_OVERFLOW = 2'b11;

  localparam logic [3:0] ST_IDLE    = 4'b0001;
  localparam logic [3:0] ST_RECV    = 4'b0010;
  localparam logic [3:0] ST_LAST    = 4'b0100;
  localparam logic [3:0] ST_DISCARD = 4'b1000;

endpackage

// File: rtl/utmi_rx_framer.sv
// UTMI receive byte stream to AXI4-Stream framer: one hold byte delays output
// so TLAST can be attached when RxActive drops; errors truncate the packet.
module utmi_rx_framer
  import utmi_rx_framer_pkg::*;
#(
  parameter int unsigned MAX_PACKET_LEN = MAX_PACKET_LEN_DEF,
  parameter int unsigned LEN_WIDTH      = 11
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       utmi_rxactive_i,
  input  logic       utmi_rxvalid_i,
  input  logic       utmi_rxerror_i,
  input  logic [7:0] utmi_data_i,
  output logic       m_tvalid_o,
  input  logic       m_tready_i,
  output logic       m_tlast_o,
  output logic [7:0] m_tdata_o,
  output logic       rx_busy_o,
  output logic       rx_err_o,
  output logic [1:0] rx_err_type_o
);

  localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(MAX_PACKET_LEN);

  logic [3:0]           state_q, state_d;
  logic [7:0]           hold_q, hold_d;
  logic                 hold_vld_q, hold_vld_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic                 tvalid_q, tvalid_d;
  logic                 tlast_q, tlast_d;
  logic [7:0]           tdata_q, tdata_d;
  logic                 err_q, err_d;
  logic [1:0]           err_type_q, err_type_d;

  logic                 out_free;
  logic                 in_pkt;
  logic                 eff_hold_vld;
  logic [LEN_WIDTH-1:0] eff_len;
  logic                 term;

  assign out_free     = !tvalid_q || m_tready_i;
  // IDLE with RxActive high is treated as the first RECV cycle so a byte
  // arriving together with the envelope start is not lost.
  assign in_pkt       = (state_q == ST_RECV) || (state_q == ST_IDLE && utmi_rxactive_i);
  assign eff_hold_vld = (state_q == ST_RECV) && hold_vld_q;
  assign eff_len      = (state_q == ST_RECV) ? len_q : '0;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    len_d      = len_q;
    tvalid_d   = tvalid_q && !m_tready_i;
    tlast_d    = tlast_q;
    tdata_d    = tdata_q;
    err_d      = 1'b0;
    err_type_d = err_type_q;
    term       = 1'b0;

    case (state_q)
      ST_IDLE, ST_RECV: begin
        if (in_pkt) begin
          state_d    = ST_RECV;
          hold_vld_d = eff_hold_vld;
          len_d      = eff_len;
          if (utmi_rxerror_i) begin
            err_d      = 1'b1;
            err_type_d = RXERR_PHY;
            term       = 1'b1;
          end else if (utmi_rxvalid_i && eff_len == MAX_LEN) begin
            err_d      = 1'b1;
            err_type_d = RXERR_BABBLE;
            term       = 1'b1;
          end else if (utmi_rxvalid_i && eff_hold_vld && !out_free) begin
            // Keep the beat already presented; it becomes the packet's last.
            err_d      = 1'b1;
            err_type_d = RXERR_OVERFLOW;
            tlast_d    = 1'b1;
            hold_vld_d = 1'b0;
            state_d    = ST_DISCARD;
          end else if (utmi_rxvalid_i) begin
            len_d = eff_len + 1'b1;
            if (eff_hold_vld) begin
              tvalid_d = 1'b1;
              tdata_d  = hold_q;
              tlast_d  = 1'b0;
            end
            hold_d     = utmi_data_i;
            hold_vld_d = 1'b1;
            if (!utmi_rxactive_i) state_d = ST_LAST;
          end else if (!utmi_rxactive_i) begin
            state_d = eff_hold_vld ? ST_LAST : ST_IDLE;
          end
        end
      end
      ST_LAST: begin
        if (out_free) begin
          tvalid_d   = 1'b1;
          tdata_d    = hold_q;
          tlast_d    = 1'b1;
          hold_vld_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      ST_DISCARD: begin
        hold_vld_d = 1'b0;
        if (!utmi_rxactive_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Truncation: flush the held byte as the last beat, or mark the beat
    // still stuck in the output slot as last if the slot cannot take it.
    if (term) begin
      hold_vld_d = 1'b0;
      state_d    = ST_DISCARD;
      if (eff_hold_vld) begin
        if (out_free) begin
          tvalid_d = 1'b1;
          tdata_d  = hold_q;
          tlast_d  = 1'b1;
        end else begin
          tlast_d = 1'b1;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      len_q      <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      tdata_q    <= '0;
      err_q      <= 1'b0;
      err_type_q <= RXERR_NONE;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      len_q      <= len_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      tdata_q    <= tdata_d;
      err_q      <= err_d;
      err_type_q <= err_type_d;
    end
  end

  assign m_tvalid_o    = tvalid_q;
  assign m_tlast_o     = tlast_q;
  assign m_tdata_o     = tdata_q;
  assign rx_busy_o     = (state_q != ST_IDLE);
  assign rx_err_o      = err_q;
  assign rx_err_type_o = err_type_q;

endmodule

// File: tb/tb_utmi_rx_framer.sv
// Directed, table-driven bench for utmi_rx_framer; a second instance with a
// 4-byte length limit covers babble.
module tb_utmi_rx_framer;

  typedef struct {
    logic       act, vld, rerr;
    logic [7:0] din;
    logic       rdy;
    logic       tv, tl;
    logic [7:0] td;
    logic       busy, err;
    logic [1:0] et;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       act = 1'b0, vld = 1'b0, rerr = 1'b0, rdy = 1'b1;
  logic [7:0] din = 8'h00;

  logic       tv_a, tl_a, busy_a, err_a;
  logic [7:0] td_a;
  logic [1:0] et_a;
  logic       tv_b, tl_b, busy_b, err_b;
  logic [7:0] td_b;
  logic [1:0] et_b;

  int n_vec = 0;
  int n_bad = 0;

  vec_t main_tbl[$];
  vec_t babble_tbl[$];

  always #5 clock = ~clock;

  utmi_rx_framer dut (
    .clock(clock), .reset(reset),
    .utmi_rxactive_i(act), .utmi_rxvalid_i(vld), .utmi_rxerror_i(rerr),
    .utmi_data_i(din),
    .m_tvalid_o(tv_a), .m_tready_i(rdy), .m_tlast_o(tl_a), .m_tdata_o(td_a),
    .rx_busy_o(busy_a), .rx_err_o(err_a), .rx_err_type_o(et_a)
  );

  utmi_rx_framer #(.MAX_PACKET_LEN(4), .LEN_WIDTH(11)) dut_b (
    .clock(clock), .reset(reset),
    .utmi_rxactive_i(act), .utmi_rxvalid_i(vld), .utmi_rxerror_i(rerr),
    .utmi_data_i(din),
    .m_tvalid_o(tv_b), .m_tready_i(rdy), .m_tlast_o(tl_b), .m_tdata_o(td_b),
    .rx_busy_o(busy_b), .rx_err_o(err_b), .rx_err_type_o(et_b)
  );

  function automatic vec_t mk(input logic a, v, e, input logic [7:0] d, input logic r,
                              input logic etv, etl, input logic [7:0] etd,
                              input logic eb, ee, input logic [1:0] eet);
    vec_t x;
    x.act = a; x.vld = v; x.rerr = e; x.din = d; x.rdy = r;
    x.tv = etv; x.tl = etl; x.td = etd; x.busy = eb; x.err = ee; x.et = eet;
    return x;
  endfunction

  // Beat data/last are only meaningful while tvalid is expected, unless full.
  task automatic check(input string name, input bit use_b, input bit full, input vec_t x);
    logic       tv, tl, busy, err;
    logic [7:0] td;
    logic [1:0] et;
    bit         ok;
    tv = use_b ? tv_b : tv_a;     tl = use_b ? tl_b : tl_a;
    td = use_b ? td_b : td_a;     busy = use_b ? busy_b : busy_a;
    err = use_b ? err_b : err_a;  et = use_b ? et_b : et_a;
    n_vec++;
    ok = (tv === x.tv) && (busy === x.busy) && (err === x.err) && (et === x.et);
    if (x.tv || full) ok = ok && (tl === x.tl) && (td === x.td);
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got tv=%b tl=%b td=%h busy=%b err=%b type=%b, want tv=%b tl=%b td=%h busy=%b err=%b type=%b",
               name, tv, tl, td, busy, err, et, x.tv, x.tl, x.td, x.busy, x.err, x.et);
    end
  endtask

  task automatic drive(input vec_t x);
    act = x.act; vld = x.vld; rerr = x.rerr; din = x.din; rdy = x.rdy;
  endtask

  task automatic step(input string name, input bit use_b, input bit full, input vec_t x);
    @(negedge clock);
    drive(x);
    @(posedge clock);
    #1;
    check(name, use_b, full, x);
  endtask

  initial begin
    // Columns: act vld err data rdy | tv tl tdata busy err type
    main_tbl.push_back(mk(0,0,0,8'h00,1, 0,0,8'h00,0,0,2'b00)); // idle after reset
    // handshake
    main_tbl.push_back(mk(1,0,0,8'h00,1, 0,0,8'h00,1,0,2'b00));
    main_tbl.push_back(mk(1,1,0,8'hD2,1, 0,0,8'h00,1,0,2'b00));
    main_tbl.push_back(mk(1,0,0,8'h00,1, 0,0,8'h00,1,0,2'b00));
    main_tbl.push_back(mk(0,0,0,8'h00,1, 0,0,8'h00,1,0,2'b00));
    main_tbl.push_back(mk(0,0,0,8'h00,1, 1,1,8'hD2,0,0,2'b00));
    main_tbl.push_back(mk(0,0,0,8'h00,1, 0,0,8'h00,0,0,2'b00));
    // token
    main_tbl.push_back(mk(1,1,0,8'hE1,1, 0,0,8'h00,1,0,2'b00));
    main_tbl.push_back(mk(1,1,0,8'h15,1, 1,0,8'hE1,1,0,2'b00));
    main_tbl.push_back(mk(1,1,0,8'h98,1, 1,0,8'h15,1,0,2'b00));
    main_tbl.push_back(mk(0,0,0,8'h00,1, 0,0,8'h00,1,0,2'b00));
    main_tbl.push_back(mk(0,0,0,8'h00,1, 1,1,8'h98,0,0,2'b00));
    main_tbl.push_back(mk(0,0,0,8'h00,1, 0,0,8'h00,0,0,2'b00));
    // DATA0 with tready toggling and rxvalid every other cycle
    main_tbl.push_back(mk(1,1,0,8'hC3,1, 0,0,8'h00,1,0,2'b00));
    main_tbl.push_back(mk(1,0,0,8'h00,0, 0,0,8'h00,1,0,2'b00));
    main_tbl.push_back(mk(1,1,0,8'h01,1, 1,0,8'hC3,1,0,2'b00));
    main_tbl.push_back(mk(1,0,0,8'h00,0, 1,0,8'hC3,1,0,2'b00));
    main_tbl.push_back(mk(1,1,0,8'h02,1, 1,0,8'h01,1,0,2'b00));
    main_tbl.push_back(mk(1,0,0,8'h00,0, 1,0,8'h01,1,0,2'b00));
    main_tbl.push_back(mk(1,1,0,8'h3F,1, 1,0,8'h02,1,0,2'b00));
    main_tbl.push_back(mk(1,0,0,8'h00,0, 1,0,8'h02,1,0,2'b00));
    main_tbl.push_back(mk(1,1,0,8'h8E,1, 1,0,8'h3F,1,0,2'b00));
    main_tbl.push_back(mk(1,0,0,8'h00,0, 1,0,8'h3F,1,0,2'b00));
    main_tbl.push_back(mk(0,0,0,8'h00,1, 0,0,8'h00,1,0,2'b00));
    main_tbl.push_back(mk(0,0,0,8'h00,0, 1,1,8'h8E,0,0,2'b00));
    main_tbl.push_back(mk(0,0,0,8'h00,1, 0,0,8'h00,0,0,2'b00));
    // empty envelope
    main_tbl.push_back(mk(1,0,0,8'h00,1, 0,0,8'h00,1,0,2'b00));
    main_tbl.push_back(mk(0,0,0,8'h00,1, 0,0,8'h00,0,0,2'b00));
    // byte with rxactive falling; rxactive rising while the last beat is stalled
    main_tbl.push_back(mk(1,1,0,8'hA1,1, 0,0,8'h00,1,0,2'b00));
    main_tbl.push_back(mk(0,1,0,8'hB2,1, 1,0,8'hA1,1,0,2'b00));
    main_tbl.push_back(mk(0,0,0,8'h00,0, 1,0,8'hA1,1,0,2'b00));
    main_tbl.push_back(mk(1,0,0,8'h00,1, 1,1,8'hB2,0,0,2'b00));
    main_tbl.push_back(mk(1,1,0,8'hC4,0, 1,1,8'hB2,1,0,2'b00));
    main_tbl.push_back(mk(0,0,0,8'h00,1, 0,0,8'h00,1,0,2'b00));
    main_tbl.push_back(mk(0,0,0,8'h00,1, 1,1,8'hC4,0,0,2'b00));
    main_tbl.push_back(mk(0,0,0,8'h00,1, 0,0,8'h00,0,0,2'b00));
    // PHY error on the third byte
    main_tbl.push_back(mk(1,1,0,8'hC3,1, 0,0,8'h00,1,0,2'b00));
    main_tbl.push_back(mk(1,1,0,8'hAA,1, 1,0,8'hC3,1,0,2'b00));
    main_tbl.push_back(mk(1,1,1,8'h55,1, 1,1,8'hAA,1,1,2'b01));
    main_tbl.push_back(mk(1,1,0,8'h66,1, 0,0,8'h00,1,0,2'b01));
    main_tbl.push_back(mk(0,0,0,8'h00,1, 0,0,8'h00,0,0,2'b01));
    main_tbl.push_back(mk(0,0,0,8'h00,1, 0,0,8'h00,0,0,2'b01));
    // overflow with tready low
    main_tbl.push_back(mk(1,1,0,8'h11,0, 0,0,8'h00,1,0,2'b01));
    main_tbl.push_back(mk(1,1,0,8'h22,0, 1,0,8'h11,1,0,2'b01));
    main_tbl.push_back(mk(1,1,0,8'h33,0, 1,1,8'h11,1,1,2'b11));
    main_tbl.push_back(mk(0,0,0,8'h00,0, 1,1,8'h11,0,0,2'b11));
    main_tbl.push_back(mk(0,0,0,8'h00,1, 0,0,8'h00,0,0,2'b11));

    // babble on the 4-byte-limit instance, 6-byte packet
    babble_tbl.push_back(mk(1,1,0,8'hA0,1, 0,0,8'h00,1,0,2'b00));
    babble_tbl.push_back(mk(1,1,0,8'hA1,1, 1,0,8'hA0,1,0,2'b00));
    babble_tbl.push_back(mk(1,1,0,8'hA2,1, 1,0,8'hA1,1,0,2'b00));
    babble_tbl.push_back(mk(1,1,0,8'hA3,1, 1,0,8'hA2,1,0,2'b00));
    babble_tbl.push_back(mk(1,1,0,8'hA4,1, 1,1,8'hA3,1,1,2'b10));
    babble_tbl.push_back(mk(1,1,0,8'hA5,1, 0,0,8'h00,1,0,2'b10));
    babble_tbl.push_back(mk(0,0,0,8'h00,1, 0,0,8'h00,0,0,2'b10));

    // Asynchronous reset at start, before any clock edge
    #1 reset = 1'b1;
    #2 check("reset_async_start", 1'b0, 1'b1, mk(0,0,0,8'h00,1, 0,0,8'h00,0,0,2'b00));
    repeat (2) @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < main_tbl.size(); i++)
      step($sformatf("main%0d", i), 1'b0, (i == 0), main_tbl[i]);

    // Reset pulse in the middle of a packet
    step("rst_pkt0", 1'b0, 1'b0, mk(1,1,0,8'h5A,0, 0,0,8'h00,1,0,2'b11));
    step("rst_pkt1", 1'b0, 1'b0, mk(1,1,0,8'h6B,0, 1,0,8'h5A,1,0,2'b11));
    @(negedge clock);
    drive(mk(1,1,0,8'h7C,0, 0,0,8'h00,0,0,2'b00));
    #2 reset = 1'b1;
    #1 check("rst_async_mid", 1'b0, 1'b1, mk(0,0,0,8'h00,0, 0,0,8'h00,0,0,2'b00));
    @(negedge clock);
    drive(mk(0,0,0,8'h00,1, 0,0,8'h00,0,0,2'b00));
    reset = 1'b0;
    step("rst_rec0", 1'b0, 1'b0, mk(1,1,0,8'hE1,1, 0,0,8'h00,1,0,2'b00));
    step("rst_rec1", 1'b0, 1'b0, mk(1,1,0,8'h15,1, 1,0,8'hE1,1,0,2'b00));
    step("rst_rec2", 1'b0, 1'b0, mk(0,0,0,8'h00,1, 0,0,8'h00,1,0,2'b00));
    step("rst_rec3", 1'b0, 1'b0, mk(0,0,0,8'h00,1, 1,1,8'h15,0,0,2'b00));
    step("rst_rec4", 1'b0, 1'b0, mk(0,0,0,8'h00,1, 0,0,8'h00,0,0,2'b00));

    for (int i = 0; i < babble_tbl.size(); i++)
      step($sformatf("babble%0d", i), 1'b1, 1'b0, babble_tbl[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
